// File: rtl/dht_pkg.sv
// Shared types and constants for the DHT11/DHT22 single-wire reader.
package dht_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START_LOW,
    ST_RELEASE,
    ST_RESP_LOW,
    ST_RESP_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_CHECK,
    ST_HOLDOFF
  } dht_state_e;

  localparam int unsigned FRAME_BITS         = 40;
  localparam int unsigned BITCNT_W           = 6;
  localparam int unsigned TIMER_W            = 32;
  localparam int unsigned START_LOW_US_DHT11 = 18000;
  localparam int unsigned START_LOW_US_DHT22 = 1000;

  // Host start-pulse length in microseconds for the selected sensor family.
  function automatic int unsigned start_low_us(input int unsigned sensor);
    return (sensor == 0) ? START_LOW_US_DHT11 : START_LOW_US_DHT22;
  endfunction

endpackage

// File: rtl/dht_us_tick.sv
// 1 us prescaler; clr restarts the count so every phase begins on a whole microsecond.
module dht_us_tick #(
  parameter int unsigned DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign tick_c = (cnt_q == CNT_W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr || tick_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dht_reader.sv
// DHT11/DHT22 reader: start pulse, response handshake, 40-bit frame capture,
// checksum validation and a holdoff before the next transaction.
module dht_reader
  import dht_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 25000000,
  parameter int unsigned SENSOR        = 0,
  parameter int unsigned BIT_THRESH_US = 50,
  parameter int unsigned TIMEOUT_US    = 200,
  parameter int unsigned HOLDOFF_MS    = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        auto_en,
  inout  wire         dht11_io,
  output logic        busy,
  output logic        data_valid,
  output logic [15:0] humidity,
  output logic [15:0] temperature,
  output logic        err_timeout,
  output logic        err_checksum
);

  localparam int unsigned DIV      = CLK_HZ / 1000000;
  localparam int unsigned START_US = start_low_us(SENSOR);
  localparam int unsigned HOLD_US  = HOLDOFF_MS * 1000;

  localparam logic [TIMER_W-1:0]  START_LAST = TIMER_W'(START_US - 1);
  localparam logic [TIMER_W-1:0]  TO_LAST    = TIMER_W'(TIMEOUT_US - 1);
  localparam logic [TIMER_W-1:0]  HOLD_LAST  = TIMER_W'(HOLD_US - 1);
  localparam logic [TIMER_W-1:0]  THRESH     = TIMER_W'(BIT_THRESH_US);
  localparam logic [BITCNT_W-1:0] LAST_BIT   = BITCNT_W'(FRAME_BITS - 1);

  dht_state_e state_q, state_d;

  logic [TIMER_W-1:0]    timer_q;
  logic [BITCNT_W-1:0]   bit_cnt_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [1:0]            sync_q;
  logic                  line_d;
  logic                  drive_q;

  logic                  tick_c;
  logic                  phase_new_c;
  logic                  line_s;
  logic                  fall_c;
  logic                  to_c;
  logic [TIMER_W-1:0]    hi_us_c;
  logic                  bit_val_c;
  logic [7:0]            sum_c;
  logic                  shift_en_c;
  logic                  load_c;
  logic                  data_valid_d;
  logic                  err_timeout_d;
  logic                  err_checksum_d;

  assign phase_new_c = (state_d != state_q);

  dht_us_tick #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr    (phase_new_c),
    .tick_c (tick_c)
  );

  // Open-drain: only ever pull low; the pull-up provides the high level.
  assign dht11_io = drive_q ? 1'b0 : 1'bz;

  assign line_s    = sync_q[1];
  assign fall_c    = line_d & ~line_s;
  assign to_c      = tick_c && (timer_q == TO_LAST);
  // Include the tick landing this cycle so a high of exactly N us reads as N.
  assign hi_us_c   = timer_q + TIMER_W'(tick_c);
  assign bit_val_c = (hi_us_c >= THRESH);
  assign sum_c     = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

  // Next-state and one-cycle result strobes.
  always_comb begin
    state_d        = state_q;
    shift_en_c     = 1'b0;
    load_c         = 1'b0;
    data_valid_d   = 1'b0;
    err_timeout_d  = 1'b0;
    err_checksum_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start || auto_en) state_d = ST_START_LOW;
      end
      ST_START_LOW: begin
        if (tick_c && (timer_q == START_LAST)) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Edge, not level: the synchroniser still holds our own start pulse for a few cycles.
        if (fall_c) begin
          state_d = ST_RESP_LOW;
        end else if (to_c) begin
          state_d       = ST_HOLDOFF;
          err_timeout_d = 1'b1;
        end
      end
      ST_RESP_LOW: begin
        if (line_s) begin
          state_d = ST_RESP_HIGH;
        end else if (to_c) begin
          state_d       = ST_HOLDOFF;
          err_timeout_d = 1'b1;
        end
      end
      ST_RESP_HIGH: begin
        if (!line_s) begin
          state_d = ST_BIT_LOW;
        end else if (to_c) begin
          state_d       = ST_HOLDOFF;
          err_timeout_d = 1'b1;
        end
      end
      ST_BIT_LOW: begin
        if (line_s) begin
          state_d = ST_BIT_HIGH;
        end else if (to_c) begin
          state_d       = ST_HOLDOFF;
          err_timeout_d = 1'b1;
        end
      end
      ST_BIT_HIGH: begin
        if (!line_s) begin
          shift_en_c = 1'b1;
          state_d    = (bit_cnt_q == LAST_BIT) ? ST_CHECK : ST_BIT_LOW;
        end else if (to_c) begin
          state_d       = ST_HOLDOFF;
          err_timeout_d = 1'b1;
        end
      end
      ST_CHECK: begin
        state_d = ST_HOLDOFF;
        if (sum_c == shift_q[7:0]) begin
          load_c       = 1'b1;
          data_valid_d = 1'b1;
        end else begin
          err_checksum_d = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (tick_c && (timer_q == HOLD_LAST)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      drive_q <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      drive_q <= (state_d == ST_START_LOW);
      busy    <= (state_d != ST_IDLE);
    end
  end

  // Two-flop synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      line_d <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], dht11_io};
      line_d <= line_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else if (phase_new_c || (state_q == ST_IDLE)) begin
      timer_q <= '0;
    end else if (tick_c) begin
      timer_q <= timer_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else if (phase_new_c && (state_d == ST_START_LOW)) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else if (shift_en_c) begin
      bit_cnt_q <= bit_cnt_q + BITCNT_W'(1);
      shift_q   <= {shift_q[FRAME_BITS-2:0], bit_val_c};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_valid   <= 1'b0;
      err_timeout  <= 1'b0;
      err_checksum <= 1'b0;
      humidity     <= '0;
      temperature  <= '0;
    end else begin
      data_valid   <= data_valid_d;
      err_timeout  <= err_timeout_d;
      err_checksum <= err_checksum_d;
      if (load_c) begin
        humidity    <= shift_q[39:24];
        temperature <= shift_q[23:8];
      end
    end
  end

endmodule

// File: doc/dht_reader.md
DHT_READER -- requirements
Module: dht_reader

Interface
REQ-001 Parameter CLK_HZ, 25000000, system clock frequency in Hz; SHALL be an integer multiple of 1000000.
REQ-002 Parameter SENSOR, 0, 0 = DHT11 timing, 1 = DHT22 timing.
REQ-003 Parameter BIT_THRESH_US, 50, data-high duration (us) at or above which a bit decodes as 1.
REQ-004 Parameter TIMEOUT_US, 200, maximum duration (us) of any wait-for-edge phase.
REQ-005 Parameter HOLDOFF_MS, 2000, minimum gap between the end of one transaction and the start of the next.
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  single-cycle request for one read.
REQ-009 auto_en  input  1  when high, a read is launched automatically each time holdoff expires.
REQ-010 dht11_io  inout  1  open-drain sensor line; driven 0 or released to high impedance, never driven 1.
REQ-011 busy  output  1  high from accepted request until holdoff ends.
REQ-012 data_valid  output  1  one-cycle pulse on checksum pass.
REQ-013 humidity  output  16  {byte0, byte1} of last good frame.
REQ-014 temperature  output  16  {byte2, byte3} of last good frame.
REQ-015 err_timeout  output  1  one-cycle pulse on any phase timeout.
REQ-016 err_checksum  output  1  one-cycle pulse on checksum mismatch.

Function
REQ-017 A 1 us tick SHALL be generated by a counter dividing clk by CLK_HZ/1000000; all phase timers count ticks.
REQ-018 The input SHALL be synchronised through 2 flops; all edge decisions use the synchronised value (2-cycle input latency).
REQ-019 States: IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK, HOLDOFF.
REQ-020 IDLE -> START_LOW on start=1 or auto_en=1; start while busy SHALL be ignored (not queued).
REQ-021 START_LOW drives line 0 for 18000 us (SENSOR=0) or 1000 us (SENSOR=1), then -> RELEASE.
REQ-022 RELEASE -> RESP_LOW on synchronised low; RESP_LOW -> RESP_HIGH on high; RESP_HIGH -> BIT_LOW on low.
REQ-023 BIT_LOW -> BIT_HIGH on high; BIT_HIGH measures high time, on low shifts in bit (1 if >= BIT_THRESH_US), MSB first.
REQ-024 After 40th bit -> CHECK; otherwise BIT_HIGH -> BIT_LOW.
REQ-025 Any of RELEASE..BIT_HIGH exceeding TIMEOUT_US SHALL pulse err_timeout and go to HOLDOFF.
REQ-026 CHECK: sum of bytes 0..3 modulo 256 equal to byte 4 -> load humidity/temperature, pulse data_valid; else pulse err_checksum; then HOLDOFF.
REQ-027 humidity/temperature SHALL change only on checksum pass; errors leave them unchanged.
REQ-028 HOLDOFF lasts HOLDOFF_MS*1000 ticks then -> IDLE; busy drops on the same cycle IDLE is entered.
REQ-029 The line SHALL be released in every state except START_LOW.
REQ-030 Bit counter 6 bits and shift register 40 bits SHALL clear on entry to START_LOW.

Reset
REQ-031 On rst: state IDLE, line released, busy 0, data_valid 0, err_timeout 0, err_checksum 0, humidity 0, temperature 0, all counters 0.
REQ-032 Reset asserted mid-transaction SHALL release the line immediately (asynchronously) and discard the partial frame.

Structure
REQ-033 Package dht_pkg SHALL hold the state enum, the per-sensor start-low constants and the frame width (40).
REQ-034 Sub-module dht_us_tick SHALL implement the 1 us prescaler; synchroniser and FSM stay in dht_reader.

Verification
REQ-035 Bench model sends 0x37,0x00,0x18,0x00,0x4F -> humidity 0x3700, temperature 0x1800, one data_valid pulse, busy held through holdoff.
REQ-036 Model sends 0x37,0x00,0x18,0x00,0x50 -> err_checksum pulse, data_valid 0, outputs keep prior values.
REQ-037 No sensor response after start -> err_timeout 200 us after release, line never driven 1, next read accepted only after holdoff.
REQ-038 start re-pulsed while busy, and rst asserted during bit 20 -> second start ignored; on reset line released and outputs 0.
REQ-039 auto_en=1, HOLDOFF_MS=1, SENSOR=1 -> start-low 1000 us, back-to-back reads spaced exactly 1000 ticks after each HOLDOFF entry.
REQ-040 Bit with 49 us high -> 0, 50 us high -> 1 (threshold boundary).
